// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend
// Conditions raw push/pop switches and the data bus for the LIFO stack:
// synchronises them, optionally debounces the switch levels, turns rising
// edges into two-cycle command strobes aligned to the stack's two-phase step,
// and tracks occupancy so over/underflowing commands never reach the stack.
// Optional feature macro: CMD_DEBOUNCE_EN (adds per-switch debounce counters).
module stack_cmd_frontend #(
  parameter int DEPTH     = 256,
  parameter int CNT_W     = 9,
  parameter int DB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_push,
  input  logic             sw_pop,
  input  logic [7:0]       data_in,
  input  logic             err_clear,
  output logic             push_o,
  output logic             pop_o,
  output logic [7:0]       data_o,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             busy,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_conflict
);

  typedef enum logic [2:0] {IDLE, WAIT_PH, ISSUE0, ISSUE1, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  // Elaboration-time sanity checks on the parameter set
  if (CNT_W < $clog2(DEPTH + 1)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to hold DEPTH");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("DB_CYCLES must be at least 1");
  end

  logic [1:0] push_sync;
  logic [1:0] pop_sync;
  logic [7:0] data_meta;
  logic [7:0] s_data;
  logic       s_push;
  logic       s_pop;
  logic       d_push;
  logic       d_pop;
  logic       d_push_q;
  logic       d_pop_q;
  logic       e_push;
  logic       e_pop;
  logic       ph;
  logic       cmd_push;
  state_t     state;

  // Two-flop synchronisers bring the asynchronous switches into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_sync <= 2'b00;
      pop_sync  <= 2'b00;
      data_meta <= 8'h00;
      s_data    <= 8'h00;
    end else begin
      push_sync <= {push_sync[0], sw_push};
      pop_sync  <= {pop_sync[0], sw_pop};
      data_meta <= data_in;
      s_data    <= data_meta;
    end
  end

  assign s_push = push_sync[1];
  assign s_pop  = pop_sync[1];

`ifdef CMD_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_push;
  logic [DB_W-1:0] db_cnt_pop;

  // Push debounce: the level only follows the input after DB_CYCLES stable cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_push      <= 1'b0;
      db_cnt_push <= '0;
    end else if (s_push == d_push) begin
      db_cnt_push <= '0;
    end else if (db_cnt_push == DB_LAST) begin
      d_push      <= s_push;
      db_cnt_push <= '0;
    end else begin
      db_cnt_push <= db_cnt_push + DB_W'(1);
    end
  end

  // Pop debounce: same filter as push, independent counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pop      <= 1'b0;
      db_cnt_pop <= '0;
    end else if (s_pop == d_pop) begin
      db_cnt_pop <= '0;
    end else if (db_cnt_pop == DB_LAST) begin
      d_pop      <= s_pop;
      db_cnt_pop <= '0;
    end else begin
      db_cnt_pop <= db_cnt_pop + DB_W'(1);
    end
  end
`else
  assign d_push = s_push;
  assign d_pop  = s_pop;
`endif

  // Registered rising-edge detection on the conditioned levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_push_q <= 1'b0;
      d_pop_q  <= 1'b0;
      e_push   <= 1'b0;
      e_pop    <= 1'b0;
    end else begin
      d_push_q <= d_push;
      d_pop_q  <= d_pop;
      e_push   <= d_push & ~d_push_q;
      e_pop    <= d_pop & ~d_pop_q;
    end
  end

  // Phase mirror of the stack's two-phase step; ph==0 is its write/decrement phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph <= 1'b0;
    end else begin
      ph <= ~ph;
    end
  end

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // Command sequencer: accepts or rejects an edge in IDLE, then issues a
  // ph-aligned two-cycle strobe followed by a guard cycle; error flags are
  // cleared first so that a same-cycle set overrides the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_push      <= 1'b0;
      push_o        <= 1'b0;
      pop_o         <= 1'b0;
      data_o        <= 8'h00;
      busy          <= 1'b0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_conflict  <= 1'b0;
    end else begin
      if (err_clear) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
        err_conflict  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (e_push && e_pop) begin
            err_conflict <= 1'b1;
          end else if (e_push && full) begin
            err_overflow <= 1'b1;
          end else if (e_pop && empty) begin
            err_underflow <= 1'b1;
          end else if (e_push || e_pop) begin
            data_o   <= s_data;
            cmd_push <= e_push;
            busy     <= 1'b1;
            if (ph) begin
              state  <= ISSUE0;
              push_o <= e_push;
              pop_o  <= e_pop;
            end else begin
              state <= WAIT_PH;
            end
          end
        end
        WAIT_PH: begin
          state  <= ISSUE0;
          push_o <= cmd_push;
          pop_o  <= ~cmd_push;
        end
        ISSUE0: begin
          state <= ISSUE1;
        end
        ISSUE1: begin
          state  <= GAP;
          push_o <= 1'b0;
          pop_o  <= 1'b0;
          if (cmd_push) begin
            if (!full) begin
              count <= count + CNT_W'(1);
            end
          end else if (!empty) begin
            count <= count - CNT_W'(1);
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          push_o <= 1'b0;
          pop_o  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// tb_stack_cmd_frontend
// Randomised self-checking bench for stack_cmd_frontend against a simple
// occupancy/flag reference model and a cycle-count view of strobe timing.
module tb_stack_cmd_frontend;

  localparam int DEPTH = 256;
  localparam int CNT_W = 9;
  localparam int DB    = 8;
`ifdef CMD_DEBOUNCE_EN
  localparam int LAT = DB;
`else
  localparam int LAT = 0;
`endif

  logic             clk;
  logic             reset;
  logic             sw_push;
  logic             sw_pop;
  logic [7:0]       data_in;
  logic             err_clear;
  logic             push_o;
  logic             pop_o;
  logic [7:0]       data_o;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             busy;
  logic             err_overflow;
  logic             err_underflow;
  logic             err_conflict;

  stack_cmd_frontend #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .DB_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_push(sw_push),
    .sw_pop(sw_pop),
    .data_in(data_in),
    .err_clear(err_clear),
    .push_o(push_o),
    .pop_o(pop_o),
    .data_o(data_o),
    .count(count),
    .empty(empty),
    .full(full),
    .busy(busy),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow),
    .err_conflict(err_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; its parity is the expected stack phase
  int k;
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  int m_count = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_cfl = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic checkState();
    checkOutput("count", 32'(count), 32'(m_count));
    checkOutput("empty", 32'(empty), 32'(m_count == 0));
    checkOutput("full", 32'(full), 32'(m_count == DEPTH));
    checkOutput("err_overflow", 32'(err_overflow), 32'(m_ovf));
    checkOutput("err_underflow", 32'(err_underflow), 32'(m_unf));
    checkOutput("err_conflict", 32'(err_conflict), 32'(m_cfl));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic errClear();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_ovf = 0;
    m_unf = 0;
    m_cfl = 0;
    @(negedge clk);
    checkState();
  endtask

  // kind: 0 = push press, 1 = pop press, 2 = both pressed together
  task automatic applyStimulus(input int kind, input logic [7:0] d, input bit clr_same);
    int  kp;
    int  exp_start;
    int  first_k;
    int  last_k;
    int  push_hi;
    int  pop_hi;
    bit  accept;
    @(negedge clk);
    data_in = d;
    repeat (3) @(negedge clk);
    kp = k + 1;
    accept = 0;
    if (clr_same) begin
      m_ovf = 0;
      m_unf = 0;
      m_cfl = 0;
    end
    if (kind == 2) begin
      m_cfl = 1;
    end else if (kind == 0) begin
      if (m_count == DEPTH) m_ovf = 1;
      else begin accept = 1; m_count++; end
    end else begin
      if (m_count == 0) m_unf = 1;
      else begin accept = 1; m_count--; end
    end
    exp_start = kp + 3 + LAT;
    if (exp_start % 2 != 0) exp_start++;
    sw_push = (kind != 1);
    sw_pop  = (kind != 0);
    first_k = -1;
    last_k  = -1;
    push_hi = 0;
    pop_hi  = 0;
    for (int i = 0; i < 14 + LAT; i++) begin
      @(negedge clk);
      err_clear = clr_same && (k == kp + 2 + LAT);
      if (push_o || pop_o) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        checkOutput("data_o", 32'(data_o), 32'(d));
        checkOutput("busy_strobe", 32'(busy), 32'd1);
      end
      push_hi += int'(push_o);
      pop_hi  += int'(pop_o);
    end
    err_clear = 1'b0;
    sw_push = 1'b0;
    sw_pop  = 1'b0;
    repeat (6 + LAT) @(negedge clk);
    checkOutput("push_width", 32'(push_hi), (accept && kind == 0) ? 32'd2 : 32'd0);
    checkOutput("pop_width", 32'(pop_hi), (accept && kind == 1) ? 32'd2 : 32'd0);
    if (accept) begin
      checkOutput("strobe_start", 32'(first_k), 32'(exp_start));
      checkOutput("strobe_end", 32'(last_k), 32'(exp_start + 1));
    end
    checkState();
  endtask

  initial begin
    int r;
    bit seen;
    reset     = 1'b1;
    sw_push   = 1'b0;
    sw_pop    = 1'b0;
    data_in   = 8'h00;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_push_o", 32'(push_o), 32'd0);
    checkOutput("rst_pop_o", 32'(pop_o), 32'd0);
    checkOutput("rst_data_o", 32'(data_o), 32'd0);
    checkState();
    reset = 1'b0;
    @(negedge clk);
    checkState();

    // Pop from empty, then a clean push of 0xA5, then a conflict
    applyStimulus(1, 8'h3C, 1'b0);
    errClear();
    applyStimulus(0, 8'hA5, 1'b0);
    applyStimulus(2, 8'h11, 1'b0);
    applyStimulus(2, 8'h22, 1'b1);

    // Random mix of commands and clears
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       applyStimulus(0, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      else if (r < 8)  applyStimulus(1, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      else if (r == 8) applyStimulus(2, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      else             errClear();
    end
    applyStimulus(1, 8'h00, 1'b1);

    // Reset asserted while a push strobe is in flight
    applyStimulus(0, 8'h77, 1'b0);
    @(negedge clk);
    data_in = 8'h99;
    repeat (3) @(negedge clk);
    sw_push = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 + LAT && !seen; i++) begin
      @(negedge clk);
      if (push_o) seen = 1;
    end
    checkOutput("rst_strobe_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_push_o", 32'(push_o), 32'd0);
    checkOutput("rst_mid_count", 32'(count), 32'd0);
    sw_push = 1'b0;
    m_count = 0;
    m_ovf = 0;
    m_unf = 0;
    m_cfl = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 8'hC3, 1'b0);

`ifdef CMD_DEBOUNCE_EN
    // A glitch shorter than the debounce window must not reach the stack
    @(negedge clk);
    sw_push = 1'b1;
    repeat (5) @(negedge clk);
    sw_push = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (push_o) seen = 1;
    end
    checkOutput("glitch_no_strobe", 32'(seen), 32'd0);
    checkState();
`endif

    // Fill to capacity, overflow once, clear, then step back down
    while (m_count < DEPTH) applyStimulus(0, 8'($urandom_range(0, 255)), 1'b0);
    checkOutput("full_at_depth", 32'(full), 32'd1);
    applyStimulus(0, 8'h5A, 1'b0);
    errClear();
    applyStimulus(1, 8'h00, 1'b0);
    applyStimulus(0, 8'hE1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_cmd_frontend.md
# stack_cmd_frontend

Input conditioning and command sequencing stage that sits directly upstream of the LIFO stack memory. It synchronises raw push/pop switch levels and the 8-bit data bus, and optionally debounces them. It converts rising edges into two-cycle command strobes aligned to the stack's two-phase step. It also tracks occupancy so over- and underflowing commands never reach the stack.

## Interface
Parameters:
- DEPTH, 256, stack capacity in entries; count saturates here.
- CNT_W, 9, width of `count` (holds 0..DEPTH).
- DB_CYCLES, 1000, consecutive stable cycles required before a debounced level changes (only with CMD_DEBOUNCE_EN).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; must be the same reset that drives the stack.
- sw_push  in  1  raw push switch level (asynchronous).
- sw_pop  in  1  raw pop switch level (asynchronous).
- data_in  in  8  raw data switches (asynchronous).
- err_clear  in  1  synchronous, clears all sticky error flags.
- push_o  out  1  push command to the stack.
- pop_o  out  1  pop command to the stack.
- data_o  out  8  data to the stack, stable while push_o is high.
- count  out  CNT_W  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_overflow, err_underflow, err_conflict  out  1 each  sticky error flags.

## Operation
- Two-flop synchroniser on sw_push, sw_pop and all 8 bits of data_in. Outputs are `s_push`, `s_pop` and `s_data`.
- Debounce stage, present only with the macro, giving levels `d_push` and `d_pop`.
- Edge detect: `e_x = d_x & ~d_x_q`, registered.
- Phase register `ph` resets to 0 and toggles every cycle. It mirrors the stack's step, so `ph==0` marks the stack's write/decrement phase.
- FSM states: IDLE, WAIT_PH, ISSUE0, ISSUE1, GAP.
  - IDLE, on an edge: latch `s_data` into data_o and latch the command. Go to ISSUE0 if the next cycle has `ph==0`; otherwise go to WAIT_PH.
  - WAIT_PH → ISSUE0 after 1 cycle.
  - ISSUE0 → ISSUE1, with the command output high in both states.
  - ISSUE1 → GAP. In this transition, count is incremented on push or decremented on pop.
  - GAP → IDLE.
- Command rejection, decided in IDLE with no strobe issued and the FSM staying in IDLE:
  - Push edge while full → set err_overflow.
  - Pop edge while empty → set err_underflow.
  - Push and pop edges in the same cycle → set err_conflict, and neither command is executed.
- Edges arriving while busy are discarded. The sticky flags are not affected.
- err_clear clears all three flags. If err_clear and a flag set occur in the same cycle, the set wins.
- count never leaves the range 0..DEPTH. full and empty are combinational from count.

## Timing
- Reset values: push_o=0, pop_o=0, data_o=0, count=0, empty=1, full=0, busy=0, all error flags 0, ph=0, FSM=IDLE.
- Reset asserted mid-command drops the strobe immediately and clears count. The stack resets with it, so the two stay consistent.
- Latency without the macro: a switch rising edge sampled at cycle 0 gives an edge at cycle 3. The strobe's first high cycle is cycle 4 or 5, depending on ph.
- Latency with the macro: add DB_CYCLES cycles. The debounce counter restarts whenever the synchronised level toggles before reaching DB_CYCLES.
- Each strobe is exactly 2 cycles wide, beginning on ph==0.
- At least one low cycle (GAP) separates consecutive strobes.
- data_o is constant from the cycle before ISSUE0 through GAP.
- Minimum command period is 4 cycles, or 5 cycles when a WAIT_PH cycle is needed.

## Configuration
- `CMD_DEBOUNCE_EN` defined: the debounce counters (one per switch, width of clog2(DB_CYCLES+1)) are instantiated. Glitches shorter than DB_CYCLES never produce an edge.
- `CMD_DEBOUNCE_EN` undefined: the debounce stage is omitted, `d_x = s_x`, and DB_CYCLES is ignored.

## Test plan
- Reset, then raise sw_push with data_in=0xA5 → push_o high exactly 2 cycles starting at ph==0; data_o=0xA5 throughout; count=1; empty=0.
- 256 push presses, then 1 more → 256 strobes; full=1; the 257th produces no strobe, sets err_overflow, and leaves count at 256; err_clear then clears it.
- Pop from reset → no pop_o, err_underflow=1, count=0.
- sw_push and sw_pop rising in the same cycle → no strobe, err_conflict=1, count unchanged.
- With CMD_DEBOUNCE_EN and DB_CYCLES=8: a 5-cycle pulse on sw_push → no strobe. A level held for 20 cycles → one strobe, with its first high cycle at cycle 12 or 13 after the rising edge.
- Reset asserted during ISSUE0 of a push → push_o=0 in the same cycle, count=0. After release, the next push strobe is aligned to ph==0.
